// File: rtl/diff_clk_monitor_pkg.sv
// diff_clk_monitor_pkg
//   Shared constants for the differential clock monitor: lock FSM state
//   encoding, counter widths and a saturating increment helper.
//   Imported by diff_pair_sync and diff_clk_monitor.
package diff_clk_monitor_pkg;

  // Lock FSM state encoding (also the value driven on the state port).
  localparam logic [1:0] ST_LOST    = 2'b00;
  localparam logic [1:0] ST_ACQUIRE = 2'b01;
  localparam logic [1:0] ST_LOCKED  = 2'b10;

  localparam int EDGE_W  = 16;
  localparam int FAULT_W = 8;

  // Add one when inc is set, holding at all-ones instead of wrapping.
  function automatic logic [EDGE_W-1:0] sat_inc(input logic [EDGE_W-1:0] value,
                                                input logic              inc);
    return (inc && (value != {EDGE_W{1'b1}})) ? value + 1'b1 : value;
  endfunction

endpackage

// File: rtl/diff_pair_sync.sv
// diff_pair_sync
//   Brings an asynchronous differential pair into the clk domain and decodes it.
//   Each leg has a 2-flop synchronizer (true leg resets to 0, complement to 1,
//   so the reset pair decodes as a valid 0). A valid pair (1,0)/(0,1) loads the
//   held value; an invalid pair (0,0)/(1,1) keeps it.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   diff_p, diff_n  differential legs, asynchronous to clk
//   held            registered decoded value (3 clk after a pin change)
//   toggle          combinational: held changes at the next clk edge
//   invalid         combinational: current synchronized pair is invalid
module diff_pair_sync
  import diff_clk_monitor_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic diff_p,
  input  logic diff_n,
  output logic held,
  output logic toggle,
  output logic invalid
);

  logic p_meta;
  logic p_sync;
  logic n_meta;
  logic n_sync;
  logic held_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_meta <= 1'b0;
      p_sync <= 1'b0;
      n_meta <= 1'b1;
      n_sync <= 1'b1;
      held   <= 1'b0;
    end else begin
      p_meta <= diff_p;
      p_sync <= p_meta;
      n_meta <= diff_n;
      n_sync <= n_meta;
      held   <= held_next;
    end
  end

  // toggle and invalid describe the sample being absorbed on the coming edge,
  // so the window logic can count it in the same cycle it takes effect.
  always_comb begin
    invalid   = (p_sync == n_sync);
    held_next = invalid ? held : p_sync;
    toggle    = (held_next != held);
  end

endmodule

// File: rtl/diff_clk_monitor.sv
// diff_clk_monitor
//   Supervises a differential clock/strobe pair: decodes it in the clk domain,
//   counts held-value transitions and invalid samples over fixed windows, and
//   runs a LOST/ACQUIRE/LOCKED state machine evaluated once per window.
//   Optional macro DIFF_CLK_MONITOR_IRQ_EN adds a lock-change interrupt.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   diff_p, diff_n  differential legs (asynchronous)
//   clear           one-cycle pulse, zeroes fault_count (wins over increment)
//   sampled         held decoded value
//   locked          high while in LOCKED
//   state           FSM state: 00 LOST, 01 ACQUIRE, 10 LOCKED
//   edge_count      transitions in the last completed window
//   fault_count     bad windows seen in ACQUIRE/LOCKED, saturating at 255
//   window_done     one-cycle pulse after each window end
//   interrupt       (IRQ_EN) lock-change request, held until acknowledged
//   interrupt_ack   (IRQ_EN) acknowledge; interrupt drops the following cycle
module diff_clk_monitor
  import diff_clk_monitor_pkg::*;
#(
  parameter int WINDOW_CYCLES = 256,
  parameter int MIN_EDGES     = 4,
  parameter int MAX_EDGES     = 128,
  parameter int INVALID_MAX   = 2,
  parameter int LOCK_WINDOWS  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               diff_p,
  input  logic               diff_n,
  input  logic               clear,
  output logic               sampled,
  output logic               locked,
  output logic [1:0]         state,
  output logic [EDGE_W-1:0]  edge_count,
  output logic [FAULT_W-1:0] fault_count,
  output logic               window_done
`ifdef DIFF_CLK_MONITOR_IRQ_EN
  ,
  output logic               interrupt,
  input  logic               interrupt_ack
`endif
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam logic [EDGE_W-1:0] MIN_E  = EDGE_W'(MIN_EDGES);
  localparam logic [EDGE_W-1:0] MAX_E  = EDGE_W'(MAX_EDGES);
  localparam logic [EDGE_W-1:0] INV_E  = EDGE_W'(INVALID_MAX);
  localparam logic [EDGE_W-1:0] LOCK_E = EDGE_W'(LOCK_WINDOWS);

  logic              toggle;
  logic              invalid;
  logic [WIN_W-1:0]  win_cnt;
  logic              wrap;
  logic [EDGE_W-1:0] trans_cnt;
  logic [EDGE_W-1:0] inv_cnt;
  logic [EDGE_W-1:0] trans_total;
  logic [EDGE_W-1:0] inv_total;
  logic              good;
  logic [EDGE_W-1:0] good_run;
  logic [EDGE_W-1:0] next_run;
  logic [1:0]        next_state;
  logic              fault_inc;

  diff_pair_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .diff_p  (diff_p),
    .diff_n  (diff_n),
    .held    (sampled),
    .toggle  (toggle),
    .invalid (invalid)
  );

  // WINDOW_CYCLES is a power of two, so the window ends when win_cnt is all ones
  // and the counter wraps to 0 by itself.
  assign wrap        = &win_cnt;
  assign trans_total = sat_inc(trans_cnt, toggle);
  assign inv_total   = sat_inc(inv_cnt, invalid);
  assign good        = (trans_total >= MIN_E) && (trans_total <= MAX_E) &&
                       (inv_total <= INV_E);

  // Lock FSM. good_run counts good windows since leaving LOST; LOCKED is taken
  // on the first good window once good_run already equals LOCK_WINDOWS, so
  // ACQUIRE always lasts at least one window.
  always_comb begin
    next_state = state;
    next_run   = good_run;
    fault_inc  = 1'b0;
    if (wrap) begin
      case (state)
        ST_LOST: begin
          if (good) begin
            next_state = ST_ACQUIRE;
            next_run   = EDGE_W'(1);
          end
        end
        ST_ACQUIRE: begin
          if (good) begin
            if (good_run >= LOCK_E) next_state = ST_LOCKED;
            else                    next_run   = good_run + 1'b1;
          end else begin
            next_state = ST_LOST;
            next_run   = '0;
            fault_inc  = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!good) begin
            next_state = ST_LOST;
            next_run   = '0;
            fault_inc  = 1'b1;
          end
        end
        default: begin
          next_state = ST_LOST;
          next_run   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt     <= '0;
      trans_cnt   <= '0;
      inv_cnt     <= '0;
      edge_count  <= '0;
      window_done <= 1'b0;
      state       <= ST_LOST;
      good_run    <= '0;
      locked      <= 1'b0;
      fault_count <= '0;
    end else begin
      win_cnt     <= win_cnt + 1'b1;
      window_done <= wrap;
      state       <= next_state;
      good_run    <= next_run;
      locked      <= (next_state == ST_LOCKED);
      // An event in the wrap cycle is reported in the closing window and also
      // seeds the next one.
      if (wrap) begin
        edge_count <= trans_total;
        trans_cnt  <= EDGE_W'(toggle);
        inv_cnt    <= EDGE_W'(invalid);
      end else begin
        trans_cnt  <= trans_total;
        inv_cnt    <= inv_total;
      end
      if (clear)
        fault_count <= '0;
      else if (fault_inc && (fault_count != {FAULT_W{1'b1}}))
        fault_count <= fault_count + 1'b1;
    end
  end

`ifdef DIFF_CLK_MONITOR_IRQ_EN
  // Request/acknowledge: interrupt is raised on any entry to or exit from
  // LOCKED and holds until a cycle with interrupt_ack high; it is low on the
  // following cycle unless a new lock change lands in that same ack cycle.
  logic lock_event;

  assign lock_event = (state == ST_LOCKED) != (next_state == ST_LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              interrupt <= 1'b0;
    else if (lock_event)    interrupt <= 1'b1;
    else if (interrupt_ack) interrupt <= 1'b0;
  end
`endif

endmodule
